// File: rtl/mem_stage_ctrl_pkg.sv
// Shared encodings for the MEM-stage controller: write-back selects, widths,
// FSM states and the latched memory-request bundle.
package mem_stage_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC8 = 2'b10,
        WB_RSV = 2'b11
    } wb_sel_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [REG_W-1:0]  wreg;
        logic              reg_we;
    } mem_bundle_t;

    // Non-memory write-back value; the reserved select falls through to ALU.
    function automatic logic [DATA_W-1:0] alu_wb_data(
        input wb_sel_e           sel,
        input logic [DATA_W-1:0] alu_res,
        input logic [DATA_W-1:0] pc_plus8
    );
        return (sel == WB_PC8) ? pc_plus8 : alu_res;
    endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Access-timeout counter: synchronous clear, count enable, and a terminal
// flag raised when the count sits at TIMEOUT-1.
module mem_timeout_cnt #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic terminal
);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign terminal = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: performs the data-memory access over req/ack, stalls
// upstream while it is outstanding, and registers the MEM/WB bundle.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_dmem_we,
    input  logic [1:0]        in_wdata_src,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_reg2_data,
    input  logic [REG_W-1:0]  in_wreg,
    input  logic              in_reg_we,
    input  logic [DATA_W-1:0] in_pc_plus8,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_we,
    output logic [REG_W-1:0]  wb_wreg,
    output logic [DATA_W-1:0] wb_data,
    output logic              misalign_err,
    output logic              bus_err
);

    state_e      state;
    mem_bundle_t lat;
    logic        cnt_done;
    logic        need_mem;
    logic        misaligned;

    assign need_mem   = in_dmem_we | (in_wdata_src == WB_MEM);
    assign misaligned = |in_alu_res[1:0];

    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == ST_IDLE),
        .en       ((state == ST_ACCESS) && !dmem_ack),
        .terminal (cnt_done)
    );

    // Request fields come straight from the latch, so they stay stable until ack.
    assign dmem_we    = lat.we;
    assign dmem_addr  = lat.addr;
    assign dmem_wdata = lat.wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            lat          <= '0;
            stall        <= 1'b0;
            dmem_req     <= 1'b0;
            wb_valid     <= 1'b0;
            wb_reg_we    <= 1'b0;
            wb_wreg      <= '0;
            wb_data      <= '0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low every cycle; only the branch that
            // completes an instruction raises them, which keeps them one cycle wide.
            wb_valid     <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (!need_mem) begin
                            wb_valid  <= 1'b1;
                            wb_reg_we <= in_reg_we;
                            wb_wreg   <= in_wreg;
                            wb_data   <= alu_wb_data(wb_sel_e'(in_wdata_src),
                                                     in_alu_res, in_pc_plus8);
                        end else if (misaligned) begin
                            wb_valid     <= 1'b1;
                            wb_reg_we    <= 1'b0;
                            wb_wreg      <= in_wreg;
                            wb_data      <= in_alu_res;
                            misalign_err <= 1'b1;
                        end else begin
                            lat.we     <= in_dmem_we;
                            lat.addr   <= {in_alu_res[DATA_W-1:2], 2'b00};
                            lat.wdata  <= in_reg2_data;
                            lat.wreg   <= in_wreg;
                            lat.reg_we <= in_reg_we;
                            state      <= ST_ACCESS;
                            stall      <= 1'b1;
                            dmem_req   <= 1'b1;
                        end
                    end
                end

                ST_ACCESS: begin
                    // Ack is tested first so it wins over a coincident timeout.
                    if (dmem_ack) begin
                        state     <= ST_IDLE;
                        stall     <= 1'b0;
                        dmem_req  <= 1'b0;
                        wb_valid  <= 1'b1;
                        wb_reg_we <= lat.reg_we;
                        wb_wreg   <= lat.wreg;
                        wb_data   <= lat.we ? lat.addr : dmem_rdata;
                    end else if (cnt_done) begin
                        state     <= ST_IDLE;
                        stall     <= 1'b0;
                        dmem_req  <= 1'b0;
                        wb_valid  <= 1'b1;
                        wb_reg_we <= 1'b0;
                        wb_wreg   <= lat.wreg;
                        bus_err   <= 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: ALU/PC8/reserved selects, loads, stores,
// misalignment, timeout, ack-at-timeout and reset during an access.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_dmem_we, in_reg_we;
    logic [1:0]  in_wdata_src;
    logic [31:0] in_alu_res, in_reg2_data, in_pc_plus8;
    logic [4:0]  in_wreg;
    logic        stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        wb_valid, wb_reg_we, misalign_err, bus_err;
    logic [4:0]  wb_wreg;
    logic [31:0] wb_data;

    int n_cmp = 0;
    int n_bad = 0;

    // Observations gathered by mem_access.
    int          req_cnt, stall_cnt;
    logic        we0, early_pulse;
    logic [31:0] addr0, wdata0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_dmem_we   (in_dmem_we),
        .in_wdata_src (in_wdata_src),
        .in_alu_res   (in_alu_res),
        .in_reg2_data (in_reg2_data),
        .in_wreg      (in_wreg),
        .in_reg_we    (in_reg_we),
        .in_pc_plus8  (in_pc_plus8),
        .stall        (stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .wb_valid     (wb_valid),
        .wb_reg_we    (wb_reg_we),
        .wb_wreg      (wb_wreg),
        .wb_data      (wb_data),
        .misalign_err (misalign_err),
        .bus_err      (bus_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] sel, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] wreg,
                         input logic rwe, input logic [31:0] pc8);
        in_valid = 1'b1; in_dmem_we = we; in_wdata_src = sel; in_alu_res = alu;
        in_reg2_data = wd; in_wreg = wreg; in_reg_we = rwe; in_pc_plus8 = pc8;
    endtask

    task automatic idle_in();
        in_valid = 1'b0; in_dmem_we = 1'b0; in_wdata_src = 2'b00; in_alu_res = '0;
        in_reg2_data = '0; in_wreg = '0; in_reg_we = 1'b0; in_pc_plus8 = '0;
    endtask

    // Accept the driven bundle, then run the access, raising ack in ACCESS cycle
    // ack_at (0 = never). Returns once dmem_req falls or after a 40-cycle budget.
    task automatic mem_access(input int ack_at, input logic [31:0] rdata);
        req_cnt = 0; stall_cnt = 0; early_pulse = 1'b0;
        step();
        idle_in();
        we0 = dmem_we; addr0 = dmem_addr; wdata0 = dmem_wdata;
        for (int k = 1; k <= 40; k++) begin
            if (dmem_req) req_cnt++;
            if (stall) stall_cnt++;
            if (wb_valid || bus_err || misalign_err) early_pulse = 1'b1;
            if (k == ack_at) begin dmem_ack = 1'b1; dmem_rdata = rdata; end
            step();
            dmem_ack = 1'b0;
            if (!dmem_req) break;
        end
        n_cmp++;
        if (dmem_req !== 1'b0) begin
            n_bad++; $display("FAIL access_bound: dmem_req=%b still high after budget", dmem_req);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({stall, dmem_req, dmem_we, wb_valid, wb_reg_we, misalign_err, bus_err} !== 7'b0 ||
            dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || wb_data !== 32'h0 || wb_wreg !== 5'h0) begin
            n_bad++; $display("FAIL reset_outputs: some output nonzero (req=%b stall=%b wbv=%b data=%h), want all 0",
                              dmem_req, stall, wb_valid, wb_data);
        end
    endtask

    task automatic test_alu_op();
        drive(1'b0, 2'b00, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 32'h0);
        step();
        idle_in();
        n_cmp++;
        if ({wb_valid, wb_reg_we, wb_wreg, wb_data, stall, dmem_req} !== {1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL alu_op: wbv=%b rwe=%b wreg=%0d data=%h stall=%b req=%b, want 1 1 5 00001234 0 0",
                              wb_valid, wb_reg_we, wb_wreg, wb_data, stall, dmem_req);
        end
        step();
        n_cmp++;
        if (wb_valid !== 1'b0 || wb_data !== 32'h1234) begin
            n_bad++; $display("FAIL bubble_hold: wbv=%b data=%h, want 0 00001234", wb_valid, wb_data);
        end
    endtask

    task automatic test_wb_select();
        drive(1'b0, 2'b10, 32'h1111_0000, 32'h0, 5'd31, 1'b1, 32'h8000_0008);
        step();
        n_cmp++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h8000_0008 || wb_wreg !== 5'd31) begin
            n_bad++; $display("FAIL sel_pc8: wbv=%b data=%h wreg=%0d, want 1 80000008 31", wb_valid, wb_data, wb_wreg);
        end
        drive(1'b0, 2'b11, 32'h0000_ABCD, 32'h0, 5'd2, 1'b0, 32'hFFFF_FFF0);
        step();
        idle_in();
        n_cmp++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h0000_ABCD || wb_reg_we !== 1'b0 || dmem_req !== 1'b0) begin
            n_bad++; $display("FAIL sel_rsv: wbv=%b data=%h rwe=%b req=%b, want 1 0000abcd 0 0",
                              wb_valid, wb_data, wb_reg_we, dmem_req);
        end
        step();
    endtask

    task automatic test_load();
        drive(1'b0, 2'b01, 32'h0000_0100, 32'h0, 5'd9, 1'b1, 32'h0);
        mem_access(3, 32'hDEAD_BEEF);
        n_cmp++;
        if (req_cnt !== 3 || stall_cnt !== 3 || addr0 !== 32'h100 || we0 !== 1'b0 || early_pulse !== 1'b0) begin
            n_bad++; $display("FAIL load_req: req=%0d stall=%0d addr=%h we=%b pulse=%b, want 3 3 00000100 0 0",
                              req_cnt, stall_cnt, addr0, we0, early_pulse);
        end
        n_cmp++;
        if ({wb_valid, wb_reg_we, wb_wreg, wb_data, stall} !== {1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0}) begin
            n_bad++; $display("FAIL load_wb: wbv=%b rwe=%b wreg=%0d data=%h stall=%b, want 1 1 9 deadbeef 0",
                              wb_valid, wb_reg_we, wb_wreg, wb_data, stall);
        end
        step();
        n_cmp++;
        if (wb_valid !== 1'b0) begin
            n_bad++; $display("FAIL load_pulse: wbv=%b, want 0", wb_valid);
        end
    endtask

    task automatic test_store();
        drive(1'b1, 2'b00, 32'h0000_0204, 32'hCAFE_0001, 5'd3, 1'b0, 32'h0);
        mem_access(1, 32'h5555_5555);
        n_cmp++;
        if (req_cnt !== 1 || we0 !== 1'b1 || wdata0 !== 32'hCAFE_0001 || addr0 !== 32'h204) begin
            n_bad++; $display("FAIL store_req: req=%0d we=%b wdata=%h addr=%h, want 1 1 cafe0001 00000204",
                              req_cnt, we0, wdata0, addr0);
        end
        n_cmp++;
        if (wb_valid !== 1'b1 || wb_reg_we !== 1'b0 || wb_data !== 32'h204) begin
            n_bad++; $display("FAIL store_wb: wbv=%b rwe=%b data=%h, want 1 0 00000204", wb_valid, wb_reg_we, wb_data);
        end
        step();
    endtask

    task automatic test_misalign();
        drive(1'b0, 2'b01, 32'h0000_0102, 32'h0, 5'd4, 1'b1, 32'h0);
        step();
        idle_in();
        n_cmp++;
        if ({misalign_err, wb_valid, wb_reg_we, dmem_req, stall, bus_err} !== 6'b110000) begin
            n_bad++; $display("FAIL misalign: err=%b wbv=%b rwe=%b req=%b stall=%b berr=%b, want 1 1 0 0 0 0",
                              misalign_err, wb_valid, wb_reg_we, dmem_req, stall, bus_err);
        end
        step();
        n_cmp++;
        if (misalign_err !== 1'b0 || wb_valid !== 1'b0) begin
            n_bad++; $display("FAIL misalign_pulse: err=%b wbv=%b, want 0 0", misalign_err, wb_valid);
        end
    endtask

    task automatic test_timeout();
        drive(1'b0, 2'b01, 32'h0000_0040, 32'h0, 5'd12, 1'b1, 32'h0);
        mem_access(0, 32'h0);
        n_cmp++;
        if (req_cnt !== 16 || stall_cnt !== 16 || early_pulse !== 1'b0) begin
            n_bad++; $display("FAIL timeout_len: req=%0d stall=%0d pulse=%b, want 16 16 0", req_cnt, stall_cnt, early_pulse);
        end
        n_cmp++;
        if ({bus_err, wb_valid, wb_reg_we, stall, dmem_req} !== 5'b11000) begin
            n_bad++; $display("FAIL timeout_wb: berr=%b wbv=%b rwe=%b stall=%b req=%b, want 1 1 0 0 0",
                              bus_err, wb_valid, wb_reg_we, stall, dmem_req);
        end
        drive(1'b0, 2'b00, 32'h0000_0055, 32'h0, 5'd7, 1'b1, 32'h0);
        step();
        idle_in();
        n_cmp++;
        if ({bus_err, wb_valid, wb_reg_we, wb_wreg, wb_data} !== {1'b0, 1'b1, 1'b1, 5'd7, 32'h55}) begin
            n_bad++; $display("FAIL after_timeout: berr=%b wbv=%b rwe=%b wreg=%0d data=%h, want 0 1 1 7 00000055",
                              bus_err, wb_valid, wb_reg_we, wb_wreg, wb_data);
        end
        step();
    endtask

    task automatic test_ack_at_timeout();
        drive(1'b0, 2'b01, 32'h0000_0080, 32'h0, 5'd13, 1'b1, 32'h0);
        mem_access(16, 32'h0BAD_F00D);
        n_cmp++;
        if ({req_cnt == 16, bus_err, wb_valid, wb_reg_we, wb_data} !== {1'b1, 1'b0, 1'b1, 1'b1, 32'h0BAD_F00D}) begin
            n_bad++; $display("FAIL ack_wins: req=%0d berr=%b wbv=%b rwe=%b data=%h, want 16 0 1 1 0badf00d",
                              req_cnt, bus_err, wb_valid, wb_reg_we, wb_data);
        end
        step();
    endtask

    task automatic test_reset_mid_access();
        drive(1'b0, 2'b01, 32'h0000_0300, 32'h0, 5'd14, 1'b1, 32'h0);
        step();
        idle_in();
        step();
        n_cmp++;
        if (dmem_req !== 1'b1 || stall !== 1'b1) begin
            n_bad++; $display("FAIL pre_reset: req=%b stall=%b, want 1 1", dmem_req, stall);
        end
        rst = 1'b0;
        #1;
        test_reset();
        step();
        rst = 1'b1;
        step();
        n_cmp++;
        if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
            n_bad++; $display("FAIL post_reset: wbv=%b req=%b, want 0 0", wb_valid, dmem_req);
        end
        drive(1'b0, 2'b01, 32'h0000_0400, 32'h0, 5'd15, 1'b1, 32'h0);
        mem_access(2, 32'h1111_2222);
        n_cmp++;
        if ({req_cnt == 2, early_pulse, wb_valid, wb_wreg, wb_data} !== {1'b1, 1'b0, 1'b1, 5'd15, 32'h1111_2222}) begin
            n_bad++; $display("FAIL reload: req=%0d pulse=%b wbv=%b wreg=%0d data=%h, want 2 0 1 15 11112222",
                              req_cnt, early_pulse, wb_valid, wb_wreg, wb_data);
        end
    endtask

    initial begin
        rst = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        idle_in();
        #12;
        test_reset();
        step();
        rst = 1'b1;
        step();
        test_alu_op();
        test_wb_select();
        test_load();
        test_store();
        test_misalign();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage consumer of the EXE/MEM pipeline register bundle: accepts ALU result, store data, destination register and write-back select.
- Performs the data-memory access over a req/ack handshake, stalling upstream while an access is outstanding.
- Emits a registered MEM/WB bundle with the final write-back data.
- Sits between the EXE/MEM register and the MEM/WB register / write-back mux.

Parameters:
- TIMEOUT, 16, cycles in ACCESS without dmem_ack before the access aborts with bus error (min 2).
- CNT_W, 5, width of the timeout counter (must hold TIMEOUT).

Ports:
- clk  input  1  clock; rising edge.
- rst  input  1  asynchronous active-low reset.
- in_valid  input  1  EXE/MEM bundle holds a real instruction (0 = bubble).
- in_dmem_we  input  1  store instruction.
- in_wdata_src  input  2  write-back select: 00 ALU, 01 MEM, 10 PC+8, 11 reserved (treated as ALU).
- in_alu_res  input  32  ALU result / memory byte address.
- in_reg2_data  input  32  store data.
- in_wreg  input  5  destination register.
- in_reg_we  input  1  register write enable.
- in_pc_plus8  input  32  link value.
- stall  output  1  hold EXE/MEM and earlier stages.
- dmem_req  output  1  memory request.
- dmem_we  output  1  request is a write.
- dmem_addr  output  32  word-aligned address.
- dmem_wdata  output  32  store data.
- dmem_ack  input  1  access complete; dmem_rdata valid this cycle.
- dmem_rdata  input  32  load data.
- wb_valid  output  1  MEM/WB bundle valid (one cycle per instruction).
- wb_reg_we  output  1  register write enable.
- wb_wreg  output  5  destination register.
- wb_data  output  32  final write-back data.
- misalign_err  output  1  pulse: memory op with addr[1:0] != 0.
- bus_err  output  1  pulse: access timed out.

Behaviour:
- Reset (async, rst=0): state IDLE; all outputs 0; latched bundle and counter 0. Reset mid-access drops dmem_req immediately; the access is lost and no wb_valid is produced.
- need_mem = in_dmem_we | (in_wdata_src == 01).
- State IDLE, stall=0:
  - in_valid=0: next cycle wb_valid=0; other wb outputs hold.
  - in_valid & !need_mem: next cycle wb_valid=1, wb_reg_we=in_reg_we, wb_wreg=in_wreg, wb_data=in_pc_plus8 for select 10, else in_alu_res. Latency 1.
  - in_valid & need_mem & addr[1:0]!=0: no request. Next cycle wb_valid=1, wb_reg_we=0, misalign_err=1 for one cycle.
  - in_valid & need_mem & aligned: latch the bundle, clear the counter, go to ACCESS.
- State ACCESS, stall=1:
  - dmem_req=1; dmem_we, dmem_addr, dmem_wdata come from the latch and are stable until ack.
  - Counter increments each cycle without ack.
  - dmem_ack=1: next cycle state IDLE, dmem_req=0, wb_valid=1, wb_reg_we=latched reg_we, wb_data=dmem_rdata for a load or latched alu_res for a store.
  - Counter reaches TIMEOUT-1 with no ack: next cycle IDLE, wb_valid=1, wb_reg_we=0, bus_err=1 for one cycle.
  - Ack and timeout in the same cycle: ack wins.
  - Inputs are ignored in ACCESS; upstream holds them via stall.
- Timing: ack in the first ACCESS cycle gives 2-cycle total latency. Stall is high from the cycle after acceptance through the ack cycle inclusive.
- wb_valid, misalign_err and bus_err are single-cycle pulses per instruction. They are never asserted while in ACCESS.
- Reserved select 11 behaves exactly as 00.

Decomposition:
- Shared constants package: write-back select encodings (ALU=00, MEM=01, PC8=10), data width 32, register index width 5, FSM state encodings (IDLE, ACCESS).
- Sub-module: mem_timeout_cnt (CNT_W counter with clear/enable and a terminal flag).
- Write-back mux and FSM stay in the top module.

Test Plan:
- ALU op: in_valid=1, select 00, alu_res=0x0000_1234, wreg=5, reg_we=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_wreg=5, stall never 1, dmem_req never 1.
- Load, ack after 3 cycles: select 01, addr=0x100, rdata=0xDEAD_BEEF -> dmem_req high 3 cycles, addr=0x100, we=0, stall high 3 cycles, then wb_data=0xDEADBEEF, wb_reg_we=1.
- Store, ack in the first cycle: dmem_we_in=1, addr=0x204, reg2=0xCAFE_0001, reg_we=0 -> one cycle with req=1, we=1, wdata=0xCAFE0001; wb_valid next cycle with wb_reg_we=0; total latency 2.
- Misaligned load addr=0x102 -> no dmem_req; next cycle misalign_err=1, wb_valid=1, wb_reg_we=0.
- Timeout: load with ack never asserted, TIMEOUT=16 -> req high exactly 16 cycles, then bus_err=1, wb_reg_we=0, state IDLE, next ALU op accepted normally.
- Reset asserted during the 2nd ACCESS cycle -> dmem_req, stall and all wb outputs 0 immediately; after release a load completes normally with no spurious wb_valid.
